im_arb: RTL and testbench
=========================

# im_arb

Two-requester arbiter for the single image-memory port (`im_a`, `im_wen_n`). It sits between the memory and two masters: the photo read/copy engine (requester 0) and the time-overlay writer (requester 1). The arbiter sequences grants round-robin with a bounded burst length and inserts one idle turnaround cycle between owners. It registers the memory address and write strobe, and tags read returns back to the issuing requester.

## Interface
- `AW`, 20: memory address width.
- `BURST`, 16: maximum consecutive transfers by one owner while the other requester waits; ≥1.
- `RD_LAT`, 1: memory read latency in cycles, counted from the cycle `im_a` is presented; ≥1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  transfer request from requester 0 / 1.
- `addr0`, `addr1`  in  AW  transfer address; valid while the matching `req` is high.
- `wen0_n`, `wen1_n`  in  1  0 = write, 1 = read; valid while the matching `req` is high.
- `gnt0`, `gnt1`  out  1  grant. A transfer occurs on each edge where `reqX && gntX`.
- `im_a`  out  AW  registered memory address.
- `im_wen_n`  out  1  registered memory write enable, active-low.
- `rvalid0`, `rvalid1`  out  1  read data on the memory bus belongs to requester 0 / 1.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE
  - OWN0
  - OWN1
  - TURN
- State registers:
  - 1-bit `last` holds the previous owner.
  - Burst counter `bcnt` is `$clog2(BURST+1)` bits wide.
- Grant rule: `gntX = (state==OWNX) && reqX`. This is combinational from registered state. At most one grant is high at any time.
- IDLE transitions:
  - Neither request: stay in IDLE.
  - Only `reqX`: go to OWNX.
  - Both requests: go to the OWN state of the requester that is not `last`.
  - On entry to an OWN state, `bcnt` := 0.
- OWNX, on every transfer: `bcnt` += 1 and `last` := X.
- OWNX exits:
  - `reqX` low and the other request high → TURN.
  - `reqX` low and the other request low → IDLE.
  - `bcnt` reaches BURST on this edge and the other request is high → TURN. The BURST-th transfer still completes.
  - `bcnt` reaches BURST and the other request is low → stay in OWNX with `bcnt` := 0.
- TURN: lasts exactly one cycle, then goes to OWN of the requester that is not `last`.
  - If that requester has dropped its request, go instead to OWN of `last` if its request is high, else to IDLE.
- Memory drive:
  - On a transfer edge, `im_a` := `addrX` and `im_wen_n` := `wenX_n`.
  - On any non-transfer edge, `im_wen_n` := 1 and `im_a` holds its value.
- Read tagging:
  - A shift pipeline of depth RD_LAT+1 carries `{valid, id}` for each read transfer.
  - `rvalidX` is high exactly RD_LAT cycles after the cycle in which the corresponding `im_a` is presented.
  - Write transfers create no tag.
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE, `last`=1 (so requester 0 wins the first tie), `bcnt`=0.
  - `im_a`=0, `im_wen_n`=1, `gnt0`=`gnt1`=0.
  - `rvalid0`=`rvalid1`=0, and the tag pipeline is cleared.
  - `busy`=0.
  - Reads in flight when reset asserts are dropped with no `rvalid`.

## Timing
- Request-to-grant latency:
  - From IDLE: 1 cycle.
  - Across an owner change: at least 2 cycles (last transfer edge → TURN → OWN).
- Transfer-to-memory: `im_a`/`im_wen_n` are presented 1 cycle after the handshake edge.
- Transfer-to-`rvalid`: 1+RD_LAT cycles after the handshake edge.
- Full-rate streaming: one transfer per cycle while the owner holds `req`.
- Bus gap:
  - At least one `im_wen_n`=1 cycle between different owners.
  - No gap between transfers of the same owner.
- Requesters must hold `addr`/`wen_n` stable while `req` is high and `gnt` is low.

## Test plan
- Single owner: `req0`=1 for 5 cycles writing addresses 0x00010..0x00014, `req1`=0.
  - `gnt0` rises 1 cycle after `req0`.
  - `im_a` steps 0x10..0x14 on consecutive cycles with `im_wen_n`=0.
  - No TURN occurs.
- Contention, BURST=4: `req0` and `req1` held high continuously from IDLE after reset.
  - Requester 0 is granted first.
  - Grant pattern is 4×`gnt0`, 1 idle cycle, 4×`gnt1`, 1 idle cycle, repeating.
  - `im_wen_n`=1 in each idle cycle.
- Read tagging, RD_LAT=2: requester 1 issues a read to 0x0ABCD at edge k.
  - `im_a`=0x0ABCD in cycle k+1.
  - `rvalid1`=1 in cycle k+3 only.
  - `rvalid0` stays 0.
- Early release: requester 0 drops `req0` after 2 transfers while `req1` is high.
  - One TURN cycle follows, then `gnt1`.
  - Requester 0's `bcnt` does not carry over to requester 1.
- Tie after history: last owner=0, return to IDLE, then `req0` and `req1` rise together.
  - `gnt1` is granted first.
- Reset mid-burst: assert reset during an OWN0 read stream with reads in flight.
  - All outputs immediately go to reset values.
  - No `rvalid` appears after reset deasserts.
  - The next tie is granted to requester 0.

Source files
------------

// File: rtl/im_arb.sv
// im_arb: round-robin arbiter for the shared image-memory port.
// Bounded bursts, one-cycle turnaround, registered bus, read tagging.
module im_arb #(
  parameter int AW     = 20,
  parameter int BURST  = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          wen0_n,
  input  logic          wen1_n,
  output logic          gnt0,
  output logic          gnt1,
  output logic [AW-1:0] im_a,
  output logic          im_wen_n,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          busy
);

  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(BURST);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1,
    TURN
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            r_last;
  logic            w_last_nx;
  logic [BW-1:0]   r_bcnt;
  logic [BW-1:0]   w_bcnt_nx;
  logic [BW-1:0]   w_bcnt_inc;
  logic            w_bend;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_xfer;
  logic            w_rd;
  logic [AW-1:0]   r_im_a;
  logic            r_im_wen_n;
  logic [RD_LAT:0] r_tv;
  logic [RD_LAT:0] r_tid;

  assign w_gnt0     = (r_state == OWN0) && req0;
  assign w_gnt1     = (r_state == OWN1) && req1;
  assign w_xfer     = w_gnt0 | w_gnt1;
  assign w_rd       = w_gnt0 ? wen0_n : wen1_n;
  assign w_bcnt_inc = r_bcnt + 1'b1;
  assign w_bend     = (w_bcnt_inc == BMAX);

  // State, owner history and burst count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_last  <= w_last_nx;
      r_bcnt  <= w_bcnt_nx;
    end
  end

  // Next-state: round robin, burst limit, turnaround
  always_comb begin
    w_state_nx = r_state;
    w_last_nx  = r_last;
    w_bcnt_nx  = r_bcnt;
    unique case (r_state)
      IDLE: begin
        w_bcnt_nx = '0;
        if (req0 && req1)
          w_state_nx = r_last ? OWN0 : OWN1;
        else if (req0)
          w_state_nx = OWN0;
        else if (req1)
          w_state_nx = OWN1;
      end
      OWN0: begin
        if (req0) begin
          w_last_nx = 1'b0;
          if (w_bend) begin
            w_bcnt_nx = '0;
            if (req1) w_state_nx = TURN;
          end else begin
            w_bcnt_nx = w_bcnt_inc;
          end
        end else begin
          w_state_nx = req1 ? TURN : IDLE;
        end
      end
      OWN1: begin
        if (req1) begin
          w_last_nx = 1'b1;
          if (w_bend) begin
            w_bcnt_nx = '0;
            if (req0) w_state_nx = TURN;
          end else begin
            w_bcnt_nx = w_bcnt_inc;
          end
        end else begin
          w_state_nx = req0 ? TURN : IDLE;
        end
      end
      TURN: begin
        w_bcnt_nx = '0;
        if (r_last ? req0 : req1)
          w_state_nx = r_last ? OWN0 : OWN1;
        else if (r_last ? req1 : req0)
          w_state_nx = r_last ? OWN1 : OWN0;
        else
          w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Memory bus: capture on transfer, strobe idles high otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im_a     <= '0;
      r_im_wen_n <= 1'b1;
    end else if (w_gnt0) begin
      r_im_a     <= addr0;
      r_im_wen_n <= wen0_n;
    end else if (w_gnt1) begin
      r_im_a     <= addr1;
      r_im_wen_n <= wen1_n;
    end else begin
      r_im_wen_n <= 1'b1;
    end
  end

  // Read tag pipeline: valid and requester id per read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tv  <= '0;
      r_tid <= '0;
    end else begin
      r_tv  <= {r_tv[RD_LAT-1:0], w_xfer & w_rd};
      r_tid <= {r_tid[RD_LAT-1:0], w_gnt1};
    end
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign im_a     = r_im_a;
  assign im_wen_n = r_im_wen_n;
  assign rvalid0  = r_tv[RD_LAT] & ~r_tid[RD_LAT];
  assign rvalid1  = r_tv[RD_LAT] & r_tid[RD_LAT];
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_im_arb.sv
// tb_im_arb: directed and random stimulus against a
// cycle-level ownership model of the image-memory arbiter.
module tb_im_arb;

  localparam int AW     = 20;
  localparam int BURST  = 4;
  localparam int RD_LAT = 2;

  logic          clk;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          wen0_n, wen1_n;
  logic          gnt0, gnt1;
  logic [AW-1:0] im_a;
  logic          im_wen_n;
  logic          rvalid0, rvalid1;
  logic          busy;

  im_arb #(
    .AW(AW),
    .BURST(BURST),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0(req0),
    .req1(req1),
    .addr0(addr0),
    .addr1(addr1),
    .wen0_n(wen0_n),
    .wen1_n(wen1_n),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .im_a(im_a),
    .im_wen_n(im_wen_n),
    .rvalid0(rvalid0),
    .rvalid1(rvalid1),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // owner: -1 nobody, 0/1 requester, 2 turnaround gap
  int            m_own;
  int            m_last;
  int            m_cnt;
  logic [AW-1:0] m_a;
  logic          m_wen;
  int            cyc;
  int            sched [int];
  bit            xf0, xf1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_last = 1;
    m_cnt  = 0;
    m_a    = '0;
    m_wen  = 1'b1;
    xf0    = 1'b0;
    xf1    = 1'b0;
    sched.delete();
  endtask

  task automatic check_outs(input bit r0, input bit r1);
    bit e0, e1, v0, v1;
    e0 = (m_own == 0) && r0;
    e1 = (m_own == 1) && r1;
    v0 = sched.exists(cyc) && sched[cyc] == 0;
    v1 = sched.exists(cyc) && sched[cyc] == 1;
    check("gnt0", 32'(gnt0), 32'(e0));
    check("gnt1", 32'(gnt1), 32'(e1));
    check("im_a", 32'(im_a), 32'(m_a));
    check("im_wen_n", 32'(im_wen_n), 32'(m_wen));
    check("rvalid0", 32'(rvalid0), 32'(v0));
    check("rvalid1", 32'(rvalid1), 32'(v1));
    check("busy", 32'(busy), 32'(m_own != -1));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit r0, input bit r1,
                      input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1,
                      input bit w0, input bit w1);
    bit rq [2];
    bit e0, e1;
    int x, p;
    req0 = r0; req1 = r1;
    addr0 = a0; addr1 = a1;
    wen0_n = w0; wen1_n = w1;
    #1;
    check_outs(r0, r1);
    rq[0] = r0;
    rq[1] = r1;
    e0 = (m_own == 0) && r0;
    e1 = (m_own == 1) && r1;
    cyc++;
    if (e0 || e1) begin
      m_a   = e0 ? a0 : a1;
      m_wen = e0 ? w0 : w1;
      if (m_wen) sched[cyc + RD_LAT] = e0 ? 0 : 1;
    end else begin
      m_wen = 1'b1;
    end
    if (m_own == -1) begin
      m_cnt = 0;
      if (r0 && r1) m_own = (m_last == 1) ? 0 : 1;
      else if (r0) m_own = 0;
      else if (r1) m_own = 1;
    end else if (m_own == 2) begin
      m_cnt = 0;
      p = 1 - m_last;
      if (rq[p]) m_own = p;
      else if (rq[m_last]) m_own = m_last;
      else m_own = -1;
    end else begin
      x = m_own;
      if (rq[x]) begin
        m_last = x;
        m_cnt++;
        if (m_cnt == BURST) begin
          m_cnt = 0;
          if (rq[1-x]) m_own = 2;
        end
      end else begin
        m_own = rq[1-x] ? 2 : -1;
      end
    end
    xf0 = e0;
    xf1 = e1;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outs(req0, req1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  bit            rr [2];
  logic [AW-1:0] ra [2];
  bit            rw [2];

  initial begin
    reset = 1'b0;
    req0 = 0; req1 = 0;
    addr0 = '0; addr1 = '0;
    wen0_n = 1; wen1_n = 1;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs(1'b0, 1'b0);
    reset = 1'b1;

    // single owner writes 0x10..0x14
    step(1, 0, 20'h10, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      step(1, 0, 20'h10 + 20'(i), 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1, 1);

    // contention from reset
    do_reset();
    for (int i = 0; i < 24; i++)
      step(1, 1, 20'h100 + 20'(i), 20'h200 + 20'(i), 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, 1);

    // read tag for requester 1
    step(0, 1, 0, 20'h0ABCD, 1, 1);
    step(0, 1, 0, 20'h0ABCD, 1, 1);
    check("tag_addr", 32'(im_a), 32'h0ABCD);
    repeat (5) step(0, 0, 0, 0, 1, 1);

    // early release by requester 0
    do_reset();
    repeat (3) step(1, 1, 20'h300, 20'h400, 0, 0);
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 20'h400 + 20'(i), 0, 0);
    repeat (2) step(0, 0, 0, 0, 1, 1);

    // tie after requester 0 owned last
    repeat (3) step(1, 0, 20'h500, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1, 1);
    repeat (4) step(1, 1, 20'h600, 20'h700, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, 1);

    // reset mid read burst
    for (int i = 0; i < 4; i++)
      step(1, 0, 20'h800 + 20'(i), 0, 1, 1);
    do_reset();
    repeat (4) step(0, 0, 0, 0, 1, 1);
    repeat (3) step(1, 1, 20'h900, 20'hA00, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1, 1);

    // random traffic
    for (int x = 0; x < 2; x++) begin
      rr[x] = 0; ra[x] = '0; rw[x] = 1;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int x = 0; x < 2; x++) begin
        bit done;
        done = (x == 0) ? xf0 : xf1;
        if (!rr[x] || done) begin
          rr[x] = ($urandom_range(3) != 0);
          ra[x] = AW'($urandom);
          rw[x] = $urandom_range(1);
        end else if ($urandom_range(15) == 0) begin
          rr[x] = 0;
        end
      end
      if ($urandom_range(499) == 0) do_reset();
      step(rr[0], rr[1], ra[0], ra[1], rw[0], rw[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
